// File: rtl/neureka_tcdm_scheduler_if.sv
// Handshake bundle between the NEUREKA streamer requesters, the scheduler and the TCDM channel.
// Signal names carry the scheduler's direction: _i are driven towards it, _o are driven by it.
// master = scheduler view; slave = requesters + TCDM port view.
//   req_valid_i/req_write_i/req_last_i/req_ready_o : per-requester beat handshake and attributes
//   sel_o/tcdm_req_o/tcdm_gnt_i                    : one-hot owner select and TCDM request handshake
//   tcdm_r_valid_i/resp_valid_o                    : in-order read response and its routed strobe
interface neureka_tcdm_scheduler_if #(
   parameter int N_REQ = 5
);
   logic [N_REQ-1:0] req_valid_i;
   logic [N_REQ-1:0] req_write_i;
   logic [N_REQ-1:0] req_last_i;
   logic [N_REQ-1:0] req_ready_o;
   logic [N_REQ-1:0] sel_o;
   logic             tcdm_req_o;
   logic             tcdm_gnt_i;
   logic             tcdm_r_valid_i;
   logic [N_REQ-1:0] resp_valid_o;

   modport master (
      input  req_valid_i, req_write_i, req_last_i, tcdm_gnt_i, tcdm_r_valid_i,
      output req_ready_o, sel_o, tcdm_req_o, resp_valid_o
   );

   modport slave (
      output req_valid_i, req_write_i, req_last_i, tcdm_gnt_i, tcdm_r_valid_i,
      input  req_ready_o, sel_o, tcdm_req_o, resp_valid_o
   );
endinterface

// File: rtl/neureka_tcdm_scheduler.sv
// Round-robin, burst-locking scheduler of the single NEUREKA TCDM master channel, with an
// in-order routing FIFO that steers each read response back to the requester that issued it.
// Latency: select/request combinational from inputs in IDLE, ready same cycle as grant, response
// strobe same cycle as tcdm_r_valid_i. Backpressure: a non-granted request is held frozen until
// grant; loads are withheld while OUTSTANDING reads are in flight (stores are never blocked).
// Ports: clk_i, rst_i (async, active high), clear_i (sync), enable_i, bus_if (master modport),
//        outstanding_o (in-flight reads), busy_o, err_o (sticky response-without-read flag).
module neureka_tcdm_scheduler #(
   parameter int N_REQ       = 5,
   parameter int OUTSTANDING = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               clear_i,
   input  logic                               enable_i,
   neureka_tcdm_scheduler_if.master           bus_if,
   output logic [$clog2(OUTSTANDING+1)-1:0]   outstanding_o,
   output logic                               busy_o,
   output logic                               err_o
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int CW = $clog2(OUTSTANDING + 1);

   typedef enum logic [1:0] {IDLE, HOLD, LOCK} state_e;

   state_e          state_q;
   logic [IW-1:0]   ptr_q;                    // round-robin start index
   logic [IW-1:0]   own_q;                    // held or locked requester
   logic [IW-1:0]   fifo_q [OUTSTANDING];     // requester index of each in-flight read
   logic [PW-1:0]   rd_q, wr_q;
   logic [CW-1:0]   cnt_q;
   logic            err_q;

   logic             can_push, win_vld, req, fire, push, pop;
   logic [N_REQ-1:0] elig, sel, resp;
   logic [IW-1:0]    win;
   int               j;

   always_comb begin
      // A pop in this cycle frees the slot a full FIFO needs for this cycle's load.
      can_push = (cnt_q < CW'(OUTSTANDING)) ||
                 (bus_if.tcdm_r_valid_i && (cnt_q == CW'(OUTSTANDING)));
      elig     = bus_if.req_valid_i & (bus_if.req_write_i | {N_REQ{can_push}});
      win      = '0;
      win_vld  = 1'b0;
      j        = 0;
      case (state_q)
         HOLD: begin
            // Frozen until grant, independent of enable_i and of the requester's valid.
            win     = own_q;
            win_vld = 1'b1;
         end
         LOCK: begin
            // Burst owner only; a full FIFO stalls the load without dropping the lock.
            win     = own_q;
            win_vld = enable_i & elig[own_q];
         end
         default: begin
            // Scan downwards so the eligible index closest to ptr_q is assigned last and wins.
            if (enable_i) begin
               for (int k = N_REQ - 1; k >= 0; k--) begin
                  j = int'(ptr_q) + k;
                  if (j >= N_REQ) j = j - N_REQ;
                  if (elig[j]) begin
                     win     = IW'(j);
                     win_vld = 1'b1;
                  end
               end
            end
         end
      endcase

      // Outputs are forced low while reset is asserted, without waiting for a clock edge.
      req  = win_vld & ~rst_i;
      fire = req & bus_if.tcdm_gnt_i;
      push = fire & ~bus_if.req_write_i[win];
      pop  = bus_if.tcdm_r_valid_i & (cnt_q != '0);

      sel = '0;
      if (req) sel[win] = 1'b1;
      resp = '0;
      if (pop && !rst_i) resp[fifo_q[rd_q]] = 1'b1;
   end

   assign bus_if.sel_o        = sel;
   assign bus_if.tcdm_req_o   = req;
   assign bus_if.req_ready_o  = sel & {N_REQ{fire}};
   assign bus_if.resp_valid_o = resp;
   assign outstanding_o       = cnt_q;
   assign busy_o              = req | (cnt_q != '0);
   assign err_o               = err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         own_q   <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < OUTSTANDING; i++) fifo_q[i] <= '0;
      end else if (clear_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         own_q   <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < OUTSTANDING; i++) fifo_q[i] <= '0;
      end else begin
         if (bus_if.tcdm_r_valid_i && (cnt_q == '0)) err_q <= 1'b1;

         if (push) begin
            fifo_q[wr_q] <= win;
            wr_q         <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase

         if (fire) begin
            if (bus_if.req_last_i[win]) begin
               state_q <= IDLE;
               ptr_q   <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
            end else begin
               state_q <= LOCK;
               own_q   <= win;
            end
         end else if (req) begin
            state_q <= HOLD;
            own_q   <= win;
         end
      end
   end
endmodule

// File: tb/tb_neureka_tcdm_scheduler.sv
// Self-checking bench for neureka_tcdm_scheduler: a queue-based reference model is compared against
// every DUT output on each falling edge, and directed scenarios pin both with literal expectations.
module tb_neureka_tcdm_scheduler;
   localparam int N   = 5;
   localparam int OUT = 4;

   logic       clk = 1'b0;
   logic       rst, clear, en, man_rv;
   logic       auto_rv = 1'b0;
   logic       auto_en = 1'b0;
   logic [2:0] outstanding;
   logic       busy, err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int due[$];
   int grant_log[$];
   int resp_log[$];

   // Reference model state: round-robin start, locked/held owner (-1 none), in-flight read owners.
   int m_q[$];
   int m_ptr  = 0;
   int m_lock = -1;
   int m_hold = -1;
   int m_max  = 0;
   bit m_err  = 1'b0;

   neureka_tcdm_scheduler_if #(.N_REQ(N)) bus();
   assign bus.tcdm_r_valid_i = auto_rv | man_rv;

   neureka_tcdm_scheduler #(.N_REQ(N), .OUTSTANDING(OUT)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .clear_i       (clear),
      .enable_i      (en),
      .bus_if        (bus),
      .outstanding_o (outstanding),
      .busy_o        (busy),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      m_ptr  = 0;
      m_lock = -1;
      m_hold = -1;
      m_err  = 1'b0;
   endtask

   // Read responses returned two cycles after the beat, when enabled.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (auto_en && due.size() > 0 && due[0] == cyc) begin
         auto_rv = 1'b1;
         void'(due.pop_front());
      end else begin
         auto_rv = 1'b0;
      end
   end

   always @(negedge clk) begin : cmp
      logic [N-1:0] v, w, l, es, er, ep;
      bit rv, can, fire;
      int esel, i;
      if (rst) begin
         m_reset();
      end else begin
         v  = bus.req_valid_i;
         w  = bus.req_write_i;
         l  = bus.req_last_i;
         rv = bus.tcdm_r_valid_i;
         can  = (m_q.size() < OUT) || (m_q.size() == OUT && rv);
         esel = -1;
         if (m_hold >= 0) esel = m_hold;
         else if (m_lock >= 0) begin
            if (en && v[m_lock] && (w[m_lock] || can)) esel = m_lock;
         end else if (en) begin
            for (int k = 0; k < N; k++) begin
               i = (m_ptr + k) % N;
               if (esel < 0 && v[i] && (w[i] || can)) esel = i;
            end
         end
         fire = (esel >= 0) && bus.tcdm_gnt_i;
         es = '0;
         if (esel >= 0) es[esel] = 1'b1;
         er = fire ? es : '0;
         ep = '0;
         if (rv && m_q.size() > 0) ep[m_q[0]] = 1'b1;

         chk("sel", 32'(bus.sel_o), 32'(es));
         chk("tcdm_req", 32'(bus.tcdm_req_o), 32'(esel >= 0));
         chk("req_ready", 32'(bus.req_ready_o), 32'(er));
         chk("resp_valid", 32'(bus.resp_valid_o), 32'(ep));
         chk("outstanding", 32'(outstanding), m_q.size());
         chk("busy", 32'(busy), 32'(esel >= 0 || m_q.size() > 0));
         chk("err", 32'(err), 32'(m_err));

         if (fire) grant_log.push_back(esel);
         if (rv && m_q.size() > 0) resp_log.push_back(m_q[0]);

         if (clear) begin
            m_reset();
         end else begin
            if (rv) begin
               if (m_q.size() > 0) void'(m_q.pop_front());
               else m_err = 1'b1;
            end
            if (fire) begin
               if (!w[esel]) begin
                  m_q.push_back(esel);
                  if (auto_en) due.push_back(cyc + 2);
               end
               if (l[esel]) begin
                  m_ptr  = (esel + 1) % N;
                  m_lock = -1;
               end else begin
                  m_lock = esel;
               end
               m_hold = -1;
            end else if (esel >= 0) begin
               m_hold = esel;
            end
            if (m_q.size() > m_max) m_max = m_q.size();
         end
      end
   end

   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] w, input logic [N-1:0] l);
      bus.req_valid_i = v;
      bus.req_write_i = w;
      bus.req_last_i  = l;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      grant_log.delete();
      resp_log.delete();
      m_max = 0;
   endtask

   initial begin : watchdog
      #20000;
      errors++;
      $display("FAIL watchdog: simulation exceeded time budget");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : main
      int exp1[6];
      int exp2[6];
      int exp4[6];
      exp1 = '{0, 2, 4, 0, 2, 4};
      exp2 = '{1, 1, 1, 1, 3, 0};
      exp4 = '{0, 0, 0, 0, 2, 0};

      rst = 1'b1; clear = 1'b0; en = 1'b1; man_rv = 1'b0;
      bus.tcdm_gnt_i = 1'b1;
      drive(5'b00001, '0, '1);
      #2;
      chk("reset_sel", 32'(bus.sel_o), 32'd0);
      chk("reset_req", 32'(bus.tcdm_req_o), 32'd0);
      chk("reset_outstanding", 32'(outstanding), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      drive('0, '0, '1);
      tick(); tick();
      rst = 1'b0;

      // Round robin over 0,2,4 with responses two cycles behind.
      clear_logs();
      auto_en = 1'b1;
      for (int c = 0; c < 6; c++) begin
         drive(5'b10101, '0, '1);
         tick();
      end
      drive('0, '0, '1);
      repeat (5) tick();
      chk("t1_grant_count", grant_log.size(), 32'd6);
      for (int k = 0; k < 6 && k < grant_log.size(); k++)
         chk($sformatf("t1_grant%0d", k), grant_log[k], exp1[k]);
      for (int k = 0; k < 3 && k < resp_log.size(); k++)
         chk($sformatf("t1_resp%0d", k), resp_log[k], exp1[k]);
      chk("t1_peak_outstanding", m_max, 32'd2);
      chk("t1_drained", 32'(outstanding), 32'd0);

      // Locked 4-beat burst from 1 while 3 waits; pointer then sits at 2.
      clear_logs();
      for (int c = 0; c < 4; c++) begin
         drive(5'b01010, 5'b01000, (c == 3) ? 5'b11111 : 5'b11101);
         @(negedge clk);
         chk($sformatf("t2_burst_sel%0d", c), 32'(bus.sel_o), 32'b00010);
         tick();
      end
      drive(5'b01001, 5'b01000, '1);
      tick();
      drive(5'b00001, 5'b01000, '1);
      tick();
      drive('0, '0, '1);
      repeat (5) tick();
      chk("t2_grant_count", grant_log.size(), 32'd6);
      for (int k = 0; k < 6 && k < grant_log.size(); k++)
         chk($sformatf("t2_grant%0d", k), grant_log[k], exp2[k]);

      // Grant withheld: selection stays frozen even after valid drops.
      clear_logs();
      bus.tcdm_gnt_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         drive(5'b00001, '0, '1);
         tick();
      end
      drive(5'b00010, '0, '1);
      @(negedge clk);
      chk("t3_hold_sel", 32'(bus.sel_o), 32'b00001);
      chk("t3_hold_req", 32'(bus.tcdm_req_o), 32'd1);
      tick();
      bus.tcdm_gnt_i = 1'b1;
      @(negedge clk);
      chk("t3_grant_sel", 32'(bus.sel_o), 32'b00001);
      chk("t3_grant_ready", 32'(bus.req_ready_o), 32'b00001);
      tick();
      @(negedge clk);
      chk("t3_next_sel", 32'(bus.sel_o), 32'b00010);
      tick();
      drive('0, '0, '1);
      repeat (5) tick();
      chk("t3_grant_count", grant_log.size(), 32'd2);

      // Full routing FIFO: stores pass, loads wait for a pop.
      clear_logs();
      auto_en = 1'b0;
      for (int c = 0; c < 4; c++) begin
         drive(5'b00001, '0, '1);
         tick();
      end
      drive(5'b00101, 5'b00100, '1);
      tick();
      drive(5'b00001, '0, '1);
      @(negedge clk);
      chk("t4_stall_req", 32'(bus.tcdm_req_o), 32'd0);
      chk("t4_full", 32'(outstanding), 32'd4);
      tick();
      man_rv = 1'b1;
      @(negedge clk);
      chk("t4_pushpop_sel", 32'(bus.sel_o), 32'b00001);
      chk("t4_pushpop_resp", 32'(bus.resp_valid_o), 32'b00001);
      tick();
      man_rv = 1'b0;
      drive('0, '0, '1);
      @(negedge clk);
      chk("t4_still_full", 32'(outstanding), 32'd4);
      tick();
      chk("t4_grant_count", grant_log.size(), 32'd6);
      for (int k = 0; k < 6 && k < grant_log.size(); k++)
         chk($sformatf("t4_grant%0d", k), grant_log[k], exp4[k]);
      man_rv = 1'b1;
      repeat (4) tick();
      man_rv = 1'b0;
      @(negedge clk);
      chk("t4_drained", 32'(outstanding), 32'd0);
      tick();

      // Response with nothing outstanding.
      man_rv = 1'b1;
      @(negedge clk);
      chk("t5_no_resp", 32'(bus.resp_valid_o), 32'd0);
      tick();
      man_rv = 1'b0;
      @(negedge clk);
      chk("t5_err_set", 32'(err), 32'd1);
      tick();
      @(negedge clk);
      chk("t5_err_sticky", 32'(err), 32'd1);
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      @(negedge clk);
      chk("t5_err_cleared", 32'(err), 32'd0);
      tick();

      // Asynchronous reset in the middle of a locked read burst.
      drive(5'b01000, 5'b01000, '1);
      tick();
      drive(5'b00010, '0, 5'b11101);
      repeat (3) tick();
      chk("t6_outstanding", 32'(outstanding), 32'd3);
      chk("t6_req_before", 32'(bus.tcdm_req_o), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_sel", 32'(bus.sel_o), 32'd0);
      chk("t6_rst_req", 32'(bus.tcdm_req_o), 32'd0);
      chk("t6_rst_ready", 32'(bus.req_ready_o), 32'd0);
      chk("t6_rst_outstanding", 32'(outstanding), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      drive('0, '0, '1);
      tick();
      rst = 1'b0;
      man_rv = 1'b1;
      tick();
      man_rv = 1'b0;
      @(negedge clk);
      chk("t6_lost_resp_err", 32'(err), 32'd1);
      tick();
      drive(5'b10100, '0, '1);
      @(negedge clk);
      chk("t6_restart_sel", 32'(bus.sel_o), 32'b00100);
      tick();
      drive('0, '0, '1);
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
